// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined MIPS main controller: instruction
// field encodings, ALU control encodings and the per-stage control bundles.
package ctrl_pkg;

  localparam int CTRL_OP_W   = 6;
  localparam int CTRL_ALUC_W = 3;

  // Opcode field encodings
  localparam logic [CTRL_OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [CTRL_OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [CTRL_OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [CTRL_OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [CTRL_OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [CTRL_OP_W-1:0] OP_J     = 6'b000010;

  // Funct field encodings for supported R-type operations
  localparam logic [CTRL_OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [CTRL_OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [CTRL_OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [CTRL_OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [CTRL_OP_W-1:0] FN_SLT = 6'b101010;

  // ALU control encodings
  localparam logic [CTRL_ALUC_W-1:0] ALU_AND = 3'b000;
  localparam logic [CTRL_ALUC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [CTRL_ALUC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [CTRL_ALUC_W-1:0] ALU_SUB = 3'b110;
  localparam logic [CTRL_ALUC_W-1:0] ALU_SLT = 3'b111;

  // Full decode result for the instruction sitting in Decode
  typedef struct packed {
    logic                   reg_write;
    logic                   mem_to_reg;
    logic                   mem_write;
    logic [CTRL_ALUC_W-1:0] alu_control;
    logic                   alu_src;
    logic                   reg_dst;
    logic                   branch;
    logic                   jump;
  } dec_ctrl_t;

  // Control carried into Execute
  typedef struct packed {
    logic                   reg_write;
    logic                   mem_to_reg;
    logic                   mem_write;
    logic [CTRL_ALUC_W-1:0] alu_control;
    logic                   alu_src;
    logic                   reg_dst;
  } e_ctrl_t;

  // Control carried into Memory
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } m_ctrl_t;

  // Control carried into Writeback
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } w_ctrl_t;

  // Strip the Decode-only fields (branch/jump act in Decode and never travel)
  function automatic e_ctrl_t dec_to_e(input dec_ctrl_t d);
    e_ctrl_t e;
    e.reg_write   = d.reg_write;
    e.mem_to_reg  = d.mem_to_reg;
    e.mem_write   = d.mem_write;
    e.alu_control = d.alu_control;
    e.alu_src     = d.alu_src;
    e.reg_dst     = d.reg_dst;
    return e;
  endfunction

  // Keep only the fields Memory and later stages still need
  function automatic m_ctrl_t e_to_m(input e_ctrl_t e);
    m_ctrl_t m;
    m.reg_write  = e.reg_write;
    m.mem_to_reg = e.mem_to_reg;
    m.mem_write  = e.mem_write;
    return m;
  endfunction

  // Keep only the fields Writeback still needs
  function automatic w_ctrl_t m_to_w(input m_ctrl_t m);
    w_ctrl_t w;
    w.reg_write  = m.reg_write;
    w.mem_to_reg = m.mem_to_reg;
    return w;
  endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational main decoder: maps Opcode/Funct of the Decode instruction to
// the control bundle. Unsupported encodings decode to all-zero controls (a NOP)
// and raise the illegal flag.
module main_decoder
  import ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  output dec_ctrl_t       ctrl,
  output logic            illegal
);

  // Opcode/funct decode; defaults give a NOP so unlisted encodings stay inert
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_control = ALU_ADD;
          FN_SUB:  ctrl.alu_control = ALU_SUB;
          FN_AND:  ctrl.alu_control = ALU_AND;
          FN_OR:   ctrl.alu_control = ALU_OR;
          FN_SLT:  ctrl.alu_control = ALU_SLT;
          default: begin
            ctrl    = '0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined main controller for the 5-stage MIPS core. Decodes the Decode
// instruction and carries its control through E/M/W registers in lockstep
// with the datapath pipeline registers.
module pipe_controller
  import ctrl_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   Opcode,
  input  logic [OP_W-1:0]   Funct,
  input  logic              branch_boolean,
  input  logic              StallD,
  input  logic              FlushE,
  output logic              PCSrc,
  output logic              JumpC,
  output logic              BranchD,
  output logic              IllegalD,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              ALUSrcB,
  output logic              RegDstE,
  output logic              RegWriteE,
  output logic              MemToRegE,
  output logic              RegWriteM,
  output logic              MemToRegM,
  output logic              MemWrite,
  output logic              RegWriteW,
  output logic              MemToReg
);

  dec_ctrl_t dec_s;
  logic      illegal_s;
  e_ctrl_t   e_r;
  m_ctrl_t   m_r;
  w_ctrl_t   w_r;

  main_decoder #(
    .OP_W(OP_W)
  ) u_main_decoder (
    .opcode  (Opcode),
    .funct   (Funct),
    .ctrl    (dec_s),
    .illegal (illegal_s)
  );

  // Decode-stage redirects; a stalled Decode may hold a stale comparison, so no redirect then
  assign PCSrc    = dec_s.branch & branch_boolean & ~StallD;
  assign JumpC    = dec_s.jump & ~StallD;
  assign BranchD  = dec_s.branch;
  assign IllegalD = illegal_s;

  // Execute control register: reset wins, a flush inserts a bubble, otherwise load Decode
  always_ff @(posedge clk) begin
    if (reset) begin
      e_r <= '0;
    end else if (FlushE) begin
      e_r <= '0;
    end else begin
      e_r <= dec_to_e(dec_s);
    end
  end

  // Memory control register: follows Execute every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      m_r <= '0;
    end else begin
      m_r <= e_to_m(e_r);
    end
  end

  // Writeback control register: follows Memory every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      w_r <= '0;
    end else begin
      w_r <= m_to_w(m_r);
    end
  end

  assign ALUControlE = e_r.alu_control;
  assign ALUSrcB     = e_r.alu_src;
  assign RegDstE     = e_r.reg_dst;
  assign RegWriteE   = e_r.reg_write;
  assign MemToRegE   = e_r.mem_to_reg;
  assign RegWriteM   = m_r.reg_write;
  assign MemToRegM   = m_r.mem_to_reg;
  assign MemWrite    = m_r.mem_write;
  assign RegWriteW   = w_r.reg_write;
  assign MemToReg    = w_r.mem_to_reg;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed self-checking bench for pipe_controller. Registered outputs are
// packed into one 12-bit vector:
// [11:9] ALUControlE [8] ALUSrcB [7] RegDstE [6] RegWriteE [5] MemToRegE
// [4] RegWriteM [3] MemToRegM [2] MemWrite [1] RegWriteW [0] MemToReg
module tb_pipe_controller;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       branch_boolean;
  logic       StallD;
  logic       FlushE;
  logic       PCSrc;
  logic       JumpC;
  logic       BranchD;
  logic       IllegalD;
  logic [2:0] ALUControlE;
  logic       ALUSrcB;
  logic       RegDstE;
  logic       RegWriteE;
  logic       MemToRegE;
  logic       RegWriteM;
  logic       MemToRegM;
  logic       MemWrite;
  logic       RegWriteW;
  logic       MemToReg;

  int checks;
  int errors;

  logic [11:0] regs_s;
  assign regs_s = {ALUControlE, ALUSrcB, RegDstE, RegWriteE, MemToRegE,
                   RegWriteM, MemToRegM, MemWrite, RegWriteW, MemToReg};

  localparam logic [11:0] V_ZERO = 12'b000_0_0_0_0_0_0_0_0_0;
  localparam logic [11:0] V_LW_E = 12'b010_1_0_1_1_0_0_0_0_0;
  localparam logic [11:0] V_LW_M = 12'b000_0_0_0_0_1_1_0_0_0;
  localparam logic [11:0] V_LW_W = 12'b000_0_0_0_0_0_0_0_1_1;

  pipe_controller dut (
    .clk            (clk),
    .reset          (reset),
    .Opcode         (Opcode),
    .Funct          (Funct),
    .branch_boolean (branch_boolean),
    .StallD         (StallD),
    .FlushE         (FlushE),
    .PCSrc          (PCSrc),
    .JumpC          (JumpC),
    .BranchD        (BranchD),
    .IllegalD       (IllegalD),
    .ALUControlE    (ALUControlE),
    .ALUSrcB        (ALUSrcB),
    .RegDstE        (RegDstE),
    .RegWriteE      (RegWriteE),
    .MemToRegE      (MemToRegE),
    .RegWriteM      (RegWriteM),
    .MemToRegM      (MemToRegM),
    .MemWrite       (MemWrite),
    .RegWriteW      (RegWriteW),
    .MemToReg       (MemToReg)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bubble instruction: R-type with funct 0 decodes as an all-zero NOP
  task automatic set_nop();
    Opcode = 6'b000000;
    Funct  = 6'b000000;
  endtask

  task automatic drain();
    set_nop();
    FlushE = 1'b0; StallD = 1'b0; branch_boolean = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [11:0] exp_v [3];
    exp_v[0] = V_LW_E;
    exp_v[1] = V_LW_E | V_LW_M;
    exp_v[2] = V_LW_E | V_LW_M | V_LW_W;
    reset = 1'b1; Opcode = 6'b100011; Funct = 6'b000000;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (regs_s !== V_ZERO) begin errors++; $display("FAIL reset_hold%0d act=%b exp=%b", i, regs_s, V_ZERO); end
      checks++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (regs_s !== exp_v[i]) begin errors++; $display("FAIL reset_release%0d act=%b exp=%b", i, regs_s, exp_v[i]); end
      checks++;
    end
    // mid-operation reset discards everything in flight
    reset = 1'b1;
    tick();
    if (regs_s !== V_ZERO) begin errors++; $display("FAIL reset_mid act=%b exp=%b", regs_s, V_ZERO); end
    checks++;
    reset = 1'b0; set_nop();
    tick();
    if (regs_s !== V_ZERO) begin errors++; $display("FAIL reset_after act=%b exp=%b", regs_s, V_ZERO); end
    checks++;
  endtask

  task automatic test_lw();
    logic [11:0] exp_v [3];
    exp_v[0] = V_LW_E; exp_v[1] = V_LW_M; exp_v[2] = V_LW_W;
    drain();
    Opcode = 6'b100011; #1;
    if (IllegalD !== 1'b0) begin errors++; $display("FAIL lw_illegal act=%b exp=0", IllegalD); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      set_nop();
      if (regs_s !== exp_v[i]) begin errors++; $display("FAIL lw_stage%0d act=%b exp=%b", i, regs_s, exp_v[i]); end
      checks++;
    end
  endtask

  task automatic test_rtype();
    logic [11:0] exp_v [3];
    exp_v[0] = 12'b110_0_1_1_0_0_0_0_0_0;
    exp_v[1] = 12'b000_0_0_0_0_1_0_0_0_0;
    exp_v[2] = 12'b000_0_0_0_0_0_0_0_1_0;
    drain();
    Opcode = 6'b000000; Funct = 6'b100010;
    for (int i = 0; i < 3; i++) begin
      tick();
      set_nop();
      if (regs_s !== exp_v[i]) begin errors++; $display("FAIL sub_stage%0d act=%b exp=%b", i, regs_s, exp_v[i]); end
      checks++;
    end
    // slt and or decode into Execute
    Funct = 6'b101010; tick();
    if (ALUControlE !== 3'b111) begin errors++; $display("FAIL slt_alu act=%b exp=111", ALUControlE); end
    checks++;
    Funct = 6'b100101; tick();
    if (ALUControlE !== 3'b001) begin errors++; $display("FAIL or_alu act=%b exp=001", ALUControlE); end
    checks++;
    // unsupported funct becomes a full NOP bubble
    drain();
    Opcode = 6'b000000; Funct = 6'b111111; #1;
    if (IllegalD !== 1'b1) begin errors++; $display("FAIL bad_funct_illegal act=%b exp=1", IllegalD); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      set_nop();
      if (regs_s !== V_ZERO) begin errors++; $display("FAIL bad_funct_stage%0d act=%b exp=%b", i, regs_s, V_ZERO); end
      checks++;
    end
    Opcode = 6'b111111; #1;
    if (IllegalD !== 1'b1) begin errors++; $display("FAIL bad_opcode_illegal act=%b exp=1", IllegalD); end
    checks++;
    set_nop();
  endtask

  task automatic test_beq();
    drain();
    Opcode = 6'b000100; branch_boolean = 1'b1; StallD = 1'b0; #1;
    if ({PCSrc, BranchD} !== 2'b11) begin errors++; $display("FAIL beq_taken act=%b exp=11", {PCSrc, BranchD}); end
    checks++;
    StallD = 1'b1; #1;
    if ({PCSrc, BranchD} !== 2'b01) begin errors++; $display("FAIL beq_stalled act=%b exp=01", {PCSrc, BranchD}); end
    checks++;
    // StallD does not hold the Execute register
    tick();
    if (regs_s !== 12'b110_0_0_0_0_0_0_0_0_0) begin errors++; $display("FAIL beq_e act=%b exp=110000000000", regs_s); end
    checks++;
    StallD = 1'b0; branch_boolean = 1'b0; #1;
    if ({PCSrc, BranchD} !== 2'b01) begin errors++; $display("FAIL beq_not_equal act=%b exp=01", {PCSrc, BranchD}); end
    checks++;
    set_nop(); branch_boolean = 1'b1; #1;
    if ({PCSrc, BranchD} !== 2'b00) begin errors++; $display("FAIL nonbranch_pcsrc act=%b exp=00", {PCSrc, BranchD}); end
    checks++;
    branch_boolean = 1'b0;
  endtask

  task automatic test_sw_flush();
    drain();
    // unflushed sw reaches Memory with MemWrite
    Opcode = 6'b101011; tick(); set_nop();
    if (regs_s !== 12'b010_1_0_0_0_0_0_0_0_0) begin errors++; $display("FAIL sw_e act=%b exp=010100000000", regs_s); end
    checks++;
    tick();
    if (regs_s !== 12'b000_0_0_0_0_0_0_1_0_0) begin errors++; $display("FAIL sw_m act=%b exp=000000000100", regs_s); end
    checks++;
    // flushed sw never writes memory
    drain();
    Opcode = 6'b101011; FlushE = 1'b1; tick();
    set_nop(); FlushE = 1'b0;
    if (regs_s !== V_ZERO) begin errors++; $display("FAIL sw_flush_e act=%b exp=%b", regs_s, V_ZERO); end
    checks++;
    tick();
    if (MemWrite !== 1'b0) begin errors++; $display("FAIL sw_flush_m act=%b exp=0", MemWrite); end
    checks++;
  endtask

  task automatic test_jump();
    drain();
    Opcode = 6'b000010; StallD = 1'b0; #1;
    if (JumpC !== 1'b1) begin errors++; $display("FAIL j_jumpc act=%b exp=1", JumpC); end
    checks++;
    StallD = 1'b1; #1;
    if (JumpC !== 1'b0) begin errors++; $display("FAIL j_stalled act=%b exp=0", JumpC); end
    checks++;
    StallD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      set_nop();
      if (regs_s !== V_ZERO) begin errors++; $display("FAIL j_stage%0d act=%b exp=%b", i, regs_s, V_ZERO); end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_v [5];
    exp_v[0] = 12'b010_1_0_1_0_0_0_0_0_0;
    exp_v[1] = 12'b010_1_0_1_1_1_0_0_0_0;
    exp_v[2] = 12'b000_0_0_0_0_1_1_0_1_0;
    exp_v[3] = 12'b000_0_0_0_0_0_0_0_1_1;
    exp_v[4] = V_ZERO;
    drain();
    Opcode = 6'b001000; tick();
    if (regs_s !== exp_v[0]) begin errors++; $display("FAIL b2b_0 act=%b exp=%b", regs_s, exp_v[0]); end
    checks++;
    Opcode = 6'b100011;
    for (int i = 1; i < 5; i++) begin
      tick();
      set_nop();
      if (regs_s !== exp_v[i]) begin errors++; $display("FAIL b2b_%0d act=%b exp=%b", i, regs_s, exp_v[i]); end
      checks++;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; set_nop();
    branch_boolean = 1'b0; StallD = 1'b0; FlushE = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_flush();
    test_jump();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
